dac_spi_serializer: RTL and testbench

- Downstream stage of the 32-oscillator summing tree.
- Accepts the tree's signed 16-bit sample and its active strobe, buffers one sample and optionally converts it to offset binary.
- Shifts the sample MSB-first to an external SPI DAC (mode 0: SCLK idles low, data changes on the falling edge, DAC samples on the rising edge).
- Flags samples lost to overrun.

---
 rtl/dac_spi_serializer.sv | 163 ++++++++++++++++
 tb/tb_dac_spi_serializer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_serializer.sv
// SPI mode-0 serializer for a 16-bit DAC, fed by the oscillator summing tree.
// One-entry holding buffer with latest-wins overrun and a drop flag.
module dac_spi_serializer #(
  parameter int unsigned CLKDIV        = 4,
  parameter int unsigned CSGAP         = 2,
  parameter bit          OFFSET_BINARY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample,
  input  logic        activein,
  output logic        sclk,
  output logic        sdata,
  output logic        cs_n,
  output logic        busy,
  output logic        dropped,
  output logic        frame_done
);

  localparam int unsigned DIV_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int unsigned GAP_W  = (CSGAP > 1) ? $clog2(CSGAP) : 1;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam logic [DATA_W-1:0] XOR_MASK = OFFSET_BINARY ? 16'h8000 : 16'h0000;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic                hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                sclk_q, sclk_d;
  logic                sdata_q, sdata_d;
  logic                cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
  logic                dropped_q, dropped_d;
  logic                frame_done_q, frame_done_d;

  logic consume_c;
  logic div_end_c;
  logic gap_end_c;

  assign consume_c = (state_q == IDLE) && hold_valid_q;
  assign div_end_c = (div_q == DIV_W'(CLKDIV - 1));
  assign gap_end_c = (gap_q == GAP_W'(CSGAP - 1));

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      div_q        <= '0;
      gap_q        <= '0;
      sclk_q       <= 1'b0;
      sdata_q      <= 1'b0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      dropped_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      div_q        <= div_d;
      gap_q        <= gap_d;
      sclk_q       <= sclk_d;
      sdata_q      <= sdata_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
      dropped_q    <= dropped_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hold_valid_q) state_d = SHIFT;
      SHIFT:   if (div_end_c && sclk_q && (bitcnt_q == '0)) state_d = GAP;
      GAP:     if (gap_end_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Buffer, shifter and SPI pin next values
  always_comb begin
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    div_d        = div_q;
    gap_d        = gap_q;
    sclk_d       = sclk_q;
    sdata_d      = sdata_q;
    cs_n_d       = cs_n_q;
    frame_done_d = 1'b0;
    busy_d       = (state_d != IDLE);
    dropped_d    = activein && hold_valid_q && !consume_c;

    // A write in the consume cycle refills the buffer, so it wins over the clear
    if (activein) begin
      hold_data_d  = sample ^ XOR_MASK;
      hold_valid_d = 1'b1;
    end else if (consume_c) begin
      hold_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (hold_valid_q) begin
          shreg_d  = hold_data_q;
          sdata_d  = hold_data_q[DATA_W-1];
          cs_n_d   = 1'b0;
          sclk_d   = 1'b0;
          bitcnt_d = CNT_W'(DATA_W - 1);
          div_d    = '0;
        end
      end
      SHIFT: begin
        if (!div_end_c) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bitcnt_q != '0) begin
            sclk_d   = 1'b0;
            shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
            sdata_d  = shreg_q[DATA_W-2];
            bitcnt_d = bitcnt_q - CNT_W'(1);
          end else begin
            sclk_d       = 1'b0;
            cs_n_d       = 1'b1;
            sdata_d      = 1'b0;
            frame_done_d = 1'b1;
            gap_d        = '0;
          end
        end
      end
      GAP: begin
        if (!gap_end_c) gap_d = gap_q + GAP_W'(1);
      end
      default: ;
    endcase
  end

  assign sclk       = sclk_q;
  assign sdata      = sdata_q;
  assign cs_n       = cs_n_q;
  assign busy       = busy_q;
  assign dropped    = dropped_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Bench for dac_spi_serializer: three instances (default, two's complement,
// fast divider) observed by a DAC-side monitor that checks a word scoreboard.
module tb_dac_spi_serializer;

  logic        clk;
  logic        rst_n;
  logic [15:0] sample;
  logic [2:0]  act;
  logic [2:0]  sclk_w, sdata_w, cs_n_w, busy_w, drop_w, fd_w;

  int n_cmp = 0;
  int n_err = 0;

  dac_spi_serializer u_dut0 (
    .clk(clk), .reset(rst_n), .sample(sample), .activein(act[0]),
    .sclk(sclk_w[0]), .sdata(sdata_w[0]), .cs_n(cs_n_w[0]), .busy(busy_w[0]),
    .dropped(drop_w[0]), .frame_done(fd_w[0]));

  dac_spi_serializer #(.CLKDIV(4), .CSGAP(2), .OFFSET_BINARY(1'b0)) u_dut1 (
    .clk(clk), .reset(rst_n), .sample(sample), .activein(act[1]),
    .sclk(sclk_w[1]), .sdata(sdata_w[1]), .cs_n(cs_n_w[1]), .busy(busy_w[1]),
    .dropped(drop_w[1]), .frame_done(fd_w[1]));

  dac_spi_serializer #(.CLKDIV(1), .CSGAP(1), .OFFSET_BINARY(1'b1)) u_dut2 (
    .clk(clk), .reset(rst_n), .sample(sample), .activein(act[2]),
    .sclk(sclk_w[2]), .sdata(sdata_w[2]), .cs_n(cs_n_w[2]), .busy(busy_w[2]),
    .dropped(drop_w[2]), .frame_done(fd_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int clkdiv_of(input int id);
    return (id == 2) ? 1 : 4;
  endfunction

  function automatic int csgap_of(input int id);
    return (id == 2) ? 1 : 2;
  endfunction

  // Scoreboard: expected DAC words per instance
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];

  task automatic push_exp(input int id, input logic [15:0] w);
    case (id)
      0:       q0.push_back(w);
      1:       q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  // DAC-side monitor state
  logic [2:0]  prev_cs = 3'b111;
  logic [2:0]  prev_sclk = 3'b000;
  logic [2:0]  in_frame = 3'b000;
  logic [15:0] word [3];
  int bits [3];
  int low_len [3];
  int high_len [3];
  int last_high [3];
  int fcnt [3];
  int starts [3];
  int drop_cnt [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      word[i] = '0; bits[i] = 0; low_len[i] = 0; high_len[i] = 0;
      last_high[i] = 0; fcnt[i] = 0; starts[i] = 0; drop_cnt[i] = 0;
    end
  end

  // Reconstruct frames as the DAC would capture them (on rising sclk)
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        in_frame[i] = 1'b0;
        high_len[i] = 0;
      end else begin
        if (drop_w[i]) drop_cnt[i]++;
        if (!cs_n_w[i]) begin
          if (prev_cs[i]) begin
            in_frame[i]  = 1'b1;
            bits[i]      = 0;
            word[i]      = '0;
            low_len[i]   = 0;
            last_high[i] = high_len[i];
            starts[i]++;
          end
          low_len[i]++;
          if (sclk_w[i] && !prev_sclk[i]) begin
            word[i] = {word[i][14:0], sdata_w[i]};
            bits[i]++;
          end
        end else begin
          if (!prev_cs[i] && in_frame[i]) begin
            logic [15:0] exp_w;
            logic        have;
            have  = 1'b1;
            exp_w = '0;
            case (i)
              0:       if (q0.size() > 0) exp_w = q0.pop_front(); else have = 1'b0;
              1:       if (q1.size() > 0) exp_w = q1.pop_front(); else have = 1'b0;
              default: if (q2.size() > 0) exp_w = q2.pop_front(); else have = 1'b0;
            endcase
            check("frame_expected", 32'(have), 32'd1);
            check("frame_word", 32'(word[i]), 32'(exp_w));
            check("frame_bits", 32'(bits[i]), 32'd16);
            check("cs_low_len", 32'(low_len[i]), 32'(32 * clkdiv_of(i)));
            check("frame_done_at_cs_rise", 32'(fd_w[i]), 32'd1);
            in_frame[i] = 1'b0;
            high_len[i] = 0;
            fcnt[i]++;
          end
          high_len[i]++;
        end
      end
      prev_cs[i]   = cs_n_w[i];
      prev_sclk[i] = sclk_w[i];
    end
  end

  task automatic pulse(input int id, input logic [15:0] s);
    @(posedge clk); #1;
    sample  = s;
    act[id] = 1'b1;
    @(posedge clk); #1;
    act[id] = 1'b0;
  endtask

  task automatic wait_frames(input int id, input int target);
    for (int c = 0; c < 2000 && fcnt[id] < target; c++) @(posedge clk);
    check("frame_timeout", 32'(fcnt[id] >= target), 32'd1);
    repeat (csgap_of(id) + 3) @(posedge clk);
  endtask

  typedef struct {
    int          id;
    logic [15:0] smp;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int d0;
    int f0;
    int s0;
    vecs[0] = '{0, 16'h8000, 16'h0000};
    vecs[1] = '{0, 16'h7FFF, 16'hFFFF};
    vecs[2] = '{0, 16'h0000, 16'h8000};
    vecs[3] = '{0, 16'hFFFF, 16'h7FFF};
    vecs[4] = '{0, 16'h5A5A, 16'hDA5A};
    vecs[5] = '{1, 16'hFFFF, 16'hFFFF};
    vecs[6] = '{1, 16'h1234, 16'h1234};
    vecs[7] = '{1, 16'h8000, 16'h8000};

    rst_n  = 1'b0;
    act    = '0;
    sample = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs_dut0", 32'({cs_n_w[0], sclk_w[0], sdata_w[0], busy_w[0], drop_w[0], fd_w[0]}), 32'b100000);
    check("reset_outs_dut2", 32'({cs_n_w[2], sclk_w[2], sdata_w[2], busy_w[2], drop_w[2], fd_w[2]}), 32'b100000);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single sample: two-edge latency to cs_n falling
    push_exp(0, 16'h9234);
    @(posedge clk); #1;
    sample = 16'h1234;
    act[0] = 1'b1;
    @(posedge clk); #1;
    act[0] = 1'b0;
    check("latency_edge1_cs_high", 32'(cs_n_w[0]), 32'd1);
    @(posedge clk); #1;
    check("latency_edge2_cs_low", 32'(cs_n_w[0]), 32'd0);
    check("busy_at_cs_fall", 32'(busy_w[0]), 32'd1);
    wait_frames(0, 1);
    check("busy_after_frame", 32'(busy_w[0]), 32'd0);

    // Table of single-frame conversions
    d0 = drop_cnt[0] + drop_cnt[1];
    for (int v = 0; v < 8; v++) begin
      f0 = fcnt[vecs[v].id];
      push_exp(vecs[v].id, vecs[v].exp);
      pulse(vecs[v].id, vecs[v].smp);
      wait_frames(vecs[v].id, f0 + 1);
    end
    check("table_no_drops", 32'(drop_cnt[0] + drop_cnt[1]), 32'(d0));

    // Overrun: samples 10 cycles apart, middle one lost
    d0 = drop_cnt[0];
    f0 = fcnt[0];
    push_exp(0, 16'h8001);
    push_exp(0, 16'h8003);
    for (int c = 0; c <= 20; c++) begin
      @(posedge clk); #1;
      act[0] = (c == 0 || c == 10 || c == 20);
      sample = (c == 0) ? 16'h0001 : (c == 10) ? 16'h0002 : 16'h0003;
    end
    @(posedge clk); #1;
    act[0] = 1'b0;
    wait_frames(0, f0 + 2);
    check("overrun_one_drop", 32'(drop_cnt[0] - d0), 32'd1);
    check("overrun_back_to_back_high", 32'(last_high[0]), 32'd3);

    // Write coincides with consume: both samples sent, no drop
    d0 = drop_cnt[0];
    f0 = fcnt[0];
    push_exp(0, 16'h8AAA);
    push_exp(0, 16'h8555);
    @(posedge clk); #1;
    sample = 16'h0AAA;
    act[0] = 1'b1;
    @(posedge clk); #1;
    sample = 16'h0555;
    @(posedge clk); #1;
    act[0] = 1'b0;
    wait_frames(0, f0 + 2);
    check("simul_consume_no_drop", 32'(drop_cnt[0] - d0), 32'd0);

    // Fast instance, activein held high for 102 cycles
    d0 = drop_cnt[2];
    f0 = fcnt[2];
    push_exp(2, 16'h8000);
    push_exp(2, 16'h8022);
    push_exp(2, 16'h8044);
    push_exp(2, 16'h8065);
    for (int k = 0; k < 102; k++) begin
      @(posedge clk); #1;
      sample = 16'(k);
      act[2] = 1'b1;
    end
    @(posedge clk); #1;
    act[2] = 1'b0;
    wait_frames(2, f0 + 4);
    check("fast_drops", 32'(drop_cnt[2] - d0), 32'd98);
    check("fast_cs_high_between", 32'(last_high[2]), 32'd2);
    check("fast_queue_drained", 32'(q2.size()), 32'd0);

    // Reset 40 cycles into a frame aborts it
    pulse(0, 16'h4321);
    for (int c = 0; c < 20 && cs_n_w[0]; c++) @(posedge clk);
    check("abort_frame_started", 32'(cs_n_w[0]), 32'd0);
    repeat (40) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_outs", 32'({cs_n_w[0], sclk_w[0], sdata_w[0], busy_w[0]}), 32'b1000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    s0 = starts[0];
    repeat (300) @(posedge clk);
    #1;
    check("abort_no_restart", 32'(starts[0]), 32'(s0));
    check("abort_cs_high", 32'(cs_n_w[0]), 32'd1);
    check("queues_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
